rtc_clock_alarm: RTL and testbench

Parametrised successor to the team's 12-hour BCD time-of-day counter. It keeps time internally in 24-hour binary and divides the enable stream down to a 1 s tick with a built-in prescaler. It selects 12-hour or 24-hour BCD display at run time, supports validated time preset and a validated hh:mm alarm, and raises a sticky alarm flag. It sits between the system tick generator and the display/CPU register interface.

---
 rtl/rtc_clock_alarm.sv | 169 ++++++++++++++++
 tb/tb_rtc_clock_alarm.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_clock_alarm.sv
// Time-of-day counter with prescaler, 12/24-hour BCD display,
// validated preset and a sticky hh:mm alarm.
module rtc_clock_alarm #(
  parameter int DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_mode24,
  input  logic       i_load,
  input  logic [7:0] i_ld_hh,
  input  logic [7:0] i_ld_mm,
  input  logic [7:0] i_ld_ss,
  input  logic       i_alm_wr,
  input  logic [7:0] i_alm_hh,
  input  logic [7:0] i_alm_mm,
  input  logic       i_alm_en,
  input  logic       i_alm_clr,
  output logic       o_pm,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic       o_tick,
  output logic       o_alarm,
  output logic       o_err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] psc;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hour;
  logic [5:0]    alm_m;
  logic [4:0]    alm_h;
  logic          tick_q;
  logic          alarm_q;
  logic          err_q;

  logic          tick;
  logic          load_ok;
  logic          alm_ok;
  logic          alm_hit;
  logic [5:0]    n_sec;
  logic [5:0]    n_min;
  logic [4:0]    n_hour;
  logic [4:0]    hdisp;

  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
           (v <= lim);
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return ({3'b0, v[7:4]} * 7'd10) + {3'b0, v[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = 4'd0;
    r = v;
    if (v >= 6'd50) begin
      t = 4'd5; r = v - 6'd50;
    end else if (v >= 6'd40) begin
      t = 4'd4; r = v - 6'd40;
    end else if (v >= 6'd30) begin
      t = 4'd3; r = v - 6'd30;
    end else if (v >= 6'd20) begin
      t = 4'd2; r = v - 6'd20;
    end else if (v >= 6'd10) begin
      t = 4'd1; r = v - 6'd10;
    end
    return {t, r[3:0]};
  endfunction

  assign tick = i_ena && (psc == PMAX);

  assign load_ok = i_load &&
                   bcd_ok(i_ld_hh, 8'h23) &&
                   bcd_ok(i_ld_mm, 8'h59) &&
                   bcd_ok(i_ld_ss, 8'h59);

  assign alm_ok = i_alm_wr &&
                  bcd_ok(i_alm_hh, 8'h23) &&
                  bcd_ok(i_alm_mm, 8'h59);

  always_comb begin
    n_sec  = sec + 6'd1;
    n_min  = min;
    n_hour = hour;
    if (sec == 6'd59) begin
      n_sec = 6'd0;
      n_min = min + 6'd1;
      if (min == 6'd59) begin
        n_min  = 6'd0;
        n_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end
    end
  end

  // Only a counted second can trigger; a load landing on the
  // alarm time is deliberately ignored.
  assign alm_hit = tick && !load_ok && i_alm_en &&
                   (n_sec == 6'd0) &&
                   (n_min == alm_m) &&
                   (n_hour == alm_h);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      psc     <= '0;
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      alm_m   <= '0;
      alm_h   <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (load_ok) begin
        psc <= '0;
      end else if (i_ena) begin
        psc <= (psc == PMAX) ? '0 : psc + 1'b1;
      end
      if (load_ok) begin
        sec  <= 6'(bcd2bin(i_ld_ss));
        min  <= 6'(bcd2bin(i_ld_mm));
        hour <= 5'(bcd2bin(i_ld_hh));
      end else if (tick) begin
        sec  <= n_sec;
        min  <= n_min;
        hour <= n_hour;
      end
      if (alm_ok) begin
        alm_m <= 6'(bcd2bin(i_alm_mm));
        alm_h <= 5'(bcd2bin(i_alm_hh));
      end
      tick_q  <= tick && !load_ok;
      alarm_q <= alm_hit || (alarm_q && !i_alm_clr);
      err_q   <= (i_load && !load_ok) ||
                 (i_alm_wr && !alm_ok);
    end
  end

  always_comb begin
    hdisp = hour;
    if (!i_mode24) begin
      unique case (1'b1)
        (hour == 5'd0):  hdisp = 5'd12;
        (hour >= 5'd1 && hour <= 5'd12): hdisp = hour;
        (hour > 5'd12):  hdisp = hour - 5'd12;
      endcase
    end
  end

  assign o_pm    = (hour >= 5'd12);
  assign o_hh    = bin2bcd({1'b0, hdisp});
  assign o_mm    = bin2bcd(min);
  assign o_ss    = bin2bcd(sec);
  assign o_tick  = tick_q;
  assign o_alarm = alarm_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_rtc_clock_alarm.sv
// Directed bench for rtc_clock_alarm: DIV=1 and DIV=4 instances
// share most inputs; u4 has its own enable.
module tb_rtc_clock_alarm;

  logic       i_clk = 1'b0;
  logic       i_rst, i_ena, ena4, i_mode24;
  logic       i_load, i_alm_wr, i_alm_en, i_alm_clr;
  logic [7:0] i_ld_hh, i_ld_mm, i_ld_ss;
  logic [7:0] i_alm_hh, i_alm_mm;

  logic       pm, tick, alarm, err;
  logic [7:0] hh, mm, ss;
  logic       pm4, tick4, alarm4, err4;
  logic [7:0] hh4, mm4, ss4;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  rtc_clock_alarm #(.DIV(1)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena),
    .i_mode24(i_mode24), .i_load(i_load),
    .i_ld_hh(i_ld_hh), .i_ld_mm(i_ld_mm), .i_ld_ss(i_ld_ss),
    .i_alm_wr(i_alm_wr), .i_alm_hh(i_alm_hh),
    .i_alm_mm(i_alm_mm), .i_alm_en(i_alm_en),
    .i_alm_clr(i_alm_clr),
    .o_pm(pm), .o_hh(hh), .o_mm(mm), .o_ss(ss),
    .o_tick(tick), .o_alarm(alarm), .o_err(err)
  );

  rtc_clock_alarm #(.DIV(4)) u4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_ena(ena4),
    .i_mode24(i_mode24), .i_load(i_load),
    .i_ld_hh(i_ld_hh), .i_ld_mm(i_ld_mm), .i_ld_ss(i_ld_ss),
    .i_alm_wr(i_alm_wr), .i_alm_hh(i_alm_hh),
    .i_alm_mm(i_alm_mm), .i_alm_en(i_alm_en),
    .i_alm_clr(i_alm_clr),
    .o_pm(pm4), .o_hh(hh4), .o_mm(mm4), .o_ss(ss4),
    .o_tick(tick4), .o_alarm(alarm4), .o_err(err4)
  );

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] h, m, s);
    i_ld_hh = h; i_ld_mm = m; i_ld_ss = s;
    i_load = 1'b1;
    cyc();
    i_load = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mode24 = 1'b0;
    cyc(); cyc();
    checks++;
    if ({hh, mm, ss} !== 24'h120000) begin
      errors++;
      $display("FAIL reset_time got %h exp 120000", {hh, mm, ss});
    end
    checks++;
    if ({pm, tick, alarm, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {pm, tick, alarm, err});
    end
    i_mode24 = 1'b1; #1;
    checks++;
    if (hh !== 8'h00) begin
      errors++;
      $display("FAIL reset_hh24 got %h exp 00", hh);
    end
    i_mode24 = 1'b0;
    i_rst = 1'b0;
  endtask

  task automatic test_count();
    int nt;
    nt = 0;
    i_ena = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (tick === 1'b1) nt++;
    end
    i_ena = 1'b0;
    checks++;
    if (nt !== 60) begin
      errors++;
      $display("FAIL count_ticks got %0d exp 60", nt);
    end
    checks++;
    if ({hh, mm, ss, pm} !== {24'h120100, 1'b0}) begin
      errors++;
      $display("FAIL count_time got %h %b exp 120100 0",
               {hh, mm, ss}, pm);
    end
  endtask

  task automatic test_hour_wrap();
    ld(8'h11, 8'h59, 8'h59);
    i_ena = 1'b1; cyc(); i_ena = 1'b0;
    checks++;
    if ({hh, mm, ss, pm} !== {24'h120000, 1'b1}) begin
      errors++;
      $display("FAIL noon got %h %b exp 120000 1",
               {hh, mm, ss}, pm);
    end
    i_mode24 = 1'b1; #1;
    checks++;
    if (hh !== 8'h12) begin
      errors++;
      $display("FAIL noon_24 got %h exp 12", hh);
    end
    ld(8'h23, 8'h59, 8'h59);
    i_ena = 1'b1; cyc(); i_ena = 1'b0;
    checks++;
    if ({hh, mm, ss, pm} !== {24'h000000, 1'b0}) begin
      errors++;
      $display("FAIL midnight24 got %h %b exp 000000 0",
               {hh, mm, ss}, pm);
    end
    i_mode24 = 1'b0; #1;
    checks++;
    if (hh !== 8'h12) begin
      errors++;
      $display("FAIL midnight12 got %h exp 12", hh);
    end
    ld(8'h13, 8'h05, 8'h00);
    checks++;
    if ({hh, mm, ss, pm} !== {24'h010500, 1'b1}) begin
      errors++;
      $display("FAIL pm12 got %h %b exp 010500 1",
               {hh, mm, ss}, pm);
    end
    i_mode24 = 1'b1; #1;
    checks++;
    if (hh !== 8'h13) begin
      errors++;
      $display("FAIL pm24 got %h exp 13", hh);
    end
  endtask

  task automatic test_prescale();
    int nt;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      ena4 = 1'b1; cyc();
      if (tick4 === 1'b1) nt++;
      ena4 = 1'b0; cyc();
      if (tick4 === 1'b1) nt++;
    end
    checks++;
    if (nt !== 2 || ss4 !== 8'h02) begin
      errors++;
      $display("FAIL div4_ticks got %0d ss %h exp 2 ss 02",
               nt, ss4);
    end
    ena4 = 1'b1; cyc(); cyc();
    ena4 = 1'b0;
    ld(8'h10, 8'h00, 8'h00);
    nt = 0;
    ena4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (tick4 === 1'b1) nt++;
    end
    checks++;
    if (nt !== 0 || ss4 !== 8'h00) begin
      errors++;
      $display("FAIL div4_early got %0d ss %h exp 0 ss 00",
               nt, ss4);
    end
    cyc();
    ena4 = 1'b0;
    checks++;
    if ({tick4, ss4} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL div4_after_load got %b %h exp 1 01",
               tick4, ss4);
    end
  endtask

  task automatic test_invalid();
    logic [23:0] bad [3];
    bad[0] = 24'h240000;
    bad[1] = 24'h005A00;
    bad[2] = 24'h000060;
    for (int i = 0; i < 3; i++) begin
      ld(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
      checks++;
      if ({err, hh, mm, ss} !== {1'b1, 24'h100000}) begin
        errors++;
        $display("FAIL bad_load%0d got %b %h exp 1 100000",
                 i, err, {hh, mm, ss});
      end
      cyc();
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL bad_load_pulse%0d got %b exp 0", i, err);
      end
    end
    i_alm_hh = 8'h30; i_alm_mm = 8'h00; i_alm_wr = 1'b1;
    i_ld_hh = 8'h99; i_load = 1'b1;
    cyc();
    i_alm_wr = 1'b0; i_load = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL both_bad got %b exp 1", err);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL both_bad_single got %b exp 0", err);
    end
    i_ena = 1'b1;
    ld(8'h05, 8'h06, 8'h07);
    i_ena = 1'b0;
    checks++;
    if ({tick, hh, mm, ss} !== {1'b0, 24'h050607}) begin
      errors++;
      $display("FAIL load_vs_tick got %b %h exp 0 050607",
               tick, {hh, mm, ss});
    end
  endtask

  task automatic test_alarm();
    i_alm_hh = 8'h07; i_alm_mm = 8'h30; i_alm_wr = 1'b1;
    i_alm_en = 1'b1;
    cyc();
    i_alm_wr = 1'b0;
    ld(8'h07, 8'h29, 8'h58);
    i_ena = 1'b1; cyc();
    checks++;
    if ({alarm, ss} !== {1'b0, 8'h59}) begin
      errors++;
      $display("FAIL alm_pre got %b %h exp 0 59", alarm, ss);
    end
    i_alm_clr = 1'b1; cyc();
    i_ena = 1'b0;
    checks++;
    if ({alarm, hh, mm, ss} !== {1'b1, 24'h073000}) begin
      errors++;
      $display("FAIL alm_set got %b %h exp 1 073000",
               alarm, {hh, mm, ss});
    end
    cyc();
    i_alm_clr = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alm_clr got %b exp 0", alarm);
    end
    ld(8'h07, 8'h30, 8'h00);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alm_by_load got %b exp 0", alarm);
    end
    i_alm_en = 1'b0;
    ld(8'h07, 8'h29, 8'h59);
    i_ena = 1'b1; cyc(); i_ena = 1'b0;
    checks++;
    if ({alarm, mm, ss} !== {1'b0, 16'h3000}) begin
      errors++;
      $display("FAIL alm_disarmed got %b %h exp 0 3000",
               alarm, {mm, ss});
    end
  endtask

  task automatic test_alarm_bad_and_reset();
    i_alm_hh = 8'h24; i_alm_mm = 8'h00; i_alm_wr = 1'b1;
    cyc();
    i_alm_wr = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL alm_bad_err got %b exp 1", err);
    end
    i_alm_en = 1'b1;
    ld(8'h07, 8'h29, 8'h59);
    i_ena = 1'b1; cyc(); i_ena = 1'b0;
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alm_kept got %b exp 1", alarm);
    end
    i_alm_en = 1'b0;
    i_ena = 1'b1; cyc();
    checks++;
    if ({alarm, ss} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL alm_sticky got %b %h exp 1 01", alarm, ss);
    end
    i_rst = 1'b1; cyc();
    i_rst = 1'b0; i_ena = 1'b0;
    checks++;
    if ({hh, mm, ss, pm, tick, alarm, err} !==
        {24'h000000, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset got %h %b exp 000000 0000",
               {hh, mm, ss}, {pm, tick, alarm, err});
    end
    checks++;
    if ({hh4, mm4, ss4} !== 24'h000000) begin
      errors++;
      $display("FAIL mid_reset4 got %h exp 000000",
               {hh4, mm4, ss4});
    end
  endtask

  initial begin
    i_rst = 1'b1; i_ena = 1'b0; ena4 = 1'b0; i_mode24 = 1'b0;
    i_load = 1'b0; i_alm_wr = 1'b0; i_alm_en = 1'b0;
    i_alm_clr = 1'b0;
    i_ld_hh = '0; i_ld_mm = '0; i_ld_ss = '0;
    i_alm_hh = '0; i_alm_mm = '0;
    test_reset();
    test_count();
    test_hour_wrap();
    test_prescale();
    test_invalid();
    test_alarm();
    test_alarm_bad_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
